// File: rtl/rv_pkg.sv
// rv_pkg -- shared definitions for the register file and its hazard scoreboard.
//   reg_idx_t : 5-bit architectural register index
//   NUM_REGS  : number of architectural registers
//   REG_X0    : index of the hard-wired zero register
package rv_pkg;

  typedef logic [4:0] reg_idx_t;

  localparam int       NUM_REGS = 32;
  localparam reg_idx_t REG_X0   = 5'd0;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if -- issue handshake and write-back bus of the scoreboard.
//   issue_valid/issue_ready : instruction handshake
//   issue_rs1/rs2, issue_use_rs1/rs2 : source indices and read enables
//   issue_rd, issue_wr_rd  : destination index and write enable
//   wb_valid, wb_reg       : write-back landing this cycle (RegWrite/writeReg)
//
// Handshake: the issuer raises issue_valid with all issue_* fields and holds
// them stable while issue_valid & ~issue_ready. The instruction is consumed on
// the rising edge where issue_valid & issue_ready are both high. issue_ready is
// combinational and may be sampled in the same cycle. The write-back bus has no
// back-pressure: wb_valid is a one-cycle event.
interface regfile_scoreboard_if;
  import rv_pkg::*;

  logic     issue_valid;
  reg_idx_t issue_rs1;
  reg_idx_t issue_rs2;
  logic     issue_use_rs1;
  logic     issue_use_rs2;
  reg_idx_t issue_rd;
  logic     issue_wr_rd;
  logic     issue_ready;
  logic     wb_valid;
  reg_idx_t wb_reg;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
    output issue_rd, issue_wr_rd, wb_valid, wb_reg,
    input  issue_ready
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
    input  issue_rd, issue_wr_rd, wb_valid, wb_reg,
    output issue_ready
  );

endinterface

// File: rtl/regfile_scoreboard_sat_counter.sv
// sat_counter -- up counter that sticks at all-ones.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset, clears the count
//   inc_i  : increment enable
//   cnt_o  : current count
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard -- hazard scoreboard and issue gate for the 32x32 register
// file. Tracks registers with a write in flight, stalls issue until all used
// sources and the destination are free, bounds outstanding writes to MAX_OUT
// and counts stall cycles.
//   CLK, RST_n   : clock and asynchronous active-low reset
//   sb           : issue handshake + write-back bus (slave side)
//   flush        : discard all in-flight state at the next edge
//   busy_mask    : pending-write bit per register (bit 0 always 0)
//   out_cnt      : number of pending writes
//   spurious_wb  : sticky, write-back to a register with nothing pending
//   stall_cycles : saturating count of stalled issue cycles
module regfile_scoreboard
  import rv_pkg::*;
#(
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  regfile_scoreboard_if.slave  sb,
  input  logic                 flush,
  output logic [NUM_REGS-1:0]  busy_mask,
  output logic [CNT_W-1:0]     out_cnt,
  output logic                 spurious_wb,
  output logic [31:0]          stall_cycles
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                spur_q, spur_d;

  logic haz;
  logic full;
  logic ready;
  logic accept;
  logic wb_live;
  logic wb_hit;
  logic wb_spur;
  logic stall_inc;

  // Hazard check uses only registered state: a write-back in this cycle
  // does not unblock an issue until the next cycle (no bypass).
  always_comb begin
    haz   = (sb.issue_use_rs1 & busy_q[sb.issue_rs1]) |
            (sb.issue_use_rs2 & busy_q[sb.issue_rs2]) |
            (sb.issue_wr_rd   & busy_q[sb.issue_rd]);
    full  = sb.issue_wr_rd & (cnt_q == CNT_W'(MAX_OUT));
    ready = sb.issue_valid & ~flush & ~haz & ~full;
  end

  assign sb.issue_ready = ready;

  always_comb begin
    accept    = ready & sb.issue_wr_rd & (sb.issue_rd != REG_X0);
    // x0 write-backs and write-backs during flush are dropped silently.
    wb_live   = sb.wb_valid & (sb.wb_reg != REG_X0) & ~flush;
    wb_hit    = wb_live & busy_q[sb.wb_reg];
    wb_spur   = wb_live & ~busy_q[sb.wb_reg];
    stall_inc = sb.issue_valid & ~ready & ~flush;
  end

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    spur_d = spur_q | wb_spur;
    if (flush) begin
      busy_d = '0;
      cnt_d  = '0;
    end else begin
      // An accept can never target a busy register, so a same-register
      // accept/write-back pair is always spurious and the set must win.
      if (wb_hit) busy_d[sb.wb_reg] = 1'b0;
      if (accept) busy_d[sb.issue_rd] = 1'b1;
      case ({accept, wb_hit})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
    busy_d[REG_X0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
      spur_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      spur_q <= spur_d;
    end
  end

  sat_counter #(
    .WIDTH (32)
  ) u_stall_cnt (
    .clk_i  (CLK),
    .rst_ni (RST_n),
    .inc_i  (stall_inc),
    .cnt_o  (stall_cycles)
  );

  assign busy_mask   = busy_q;
  assign out_cnt     = cnt_q;
  assign spurious_wb = spur_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard -- directed bench for regfile_scoreboard with an
// expected-value queue drained by a negedge monitor. Each entry is tagged with
// the cycle it belongs to, the observed quantity and its expected value.
module tb_regfile_scoreboard;

  localparam int MAX_OUT = 4;
  localparam int CNT_W   = $clog2(MAX_OUT + 1);

  localparam int K_READY = 0;
  localparam int K_BUSY  = 1;
  localparam int K_CNT   = 2;
  localparam int K_SPUR  = 3;
  localparam int K_STALL = 4;
  localparam int K_SAT   = 5;

  // ---------------- clock / reset ----------------
  logic CLK;
  logic RST_n;
  logic flush;
  logic [31:0]      busy_mask;
  logic [CNT_W-1:0] out_cnt;
  logic             spurious_wb;
  logic [31:0]      stall_cycles;
  logic             sc_inc;
  logic [3:0]       sc_cnt;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  regfile_scoreboard_if sb_if ();

  regfile_scoreboard #(
    .MAX_OUT (MAX_OUT)
  ) dut (
    .CLK          (CLK),
    .RST_n        (RST_n),
    .sb           (sb_if),
    .flush        (flush),
    .busy_mask    (busy_mask),
    .out_cnt      (out_cnt),
    .spurious_wb  (spurious_wb),
    .stall_cycles (stall_cycles)
  );

  // Narrow instance so saturation is reachable in a few cycles.
  sat_counter #(
    .WIDTH (4)
  ) u_sat4 (
    .clk_i  (CLK),
    .rst_ni (RST_n),
    .inc_i  (sc_inc),
    .cnt_o  (sc_cnt)
  );

  // ---------------- scoreboard ----------------
  // entry = {cycle[15:0], kind[7:0], value[31:0]}
  logic [55:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic push_exp(input int kind, input logic [31:0] val);
    logic [15:0] c;
    c = 16'(cyc);
    exp_q.push_back({c, 8'(kind), val});
  endtask

  function automatic string kind_name(input int k);
    case (k)
      K_READY: return "issue_ready";
      K_BUSY:  return "busy_mask";
      K_CNT:   return "out_cnt";
      K_SPUR:  return "spurious_wb";
      K_STALL: return "stall_cycles";
      default: return "sat4_cnt";
    endcase
  endfunction

  logic [55:0] mon_e;
  logic [31:0] mon_act;
  int          mon_kind;
  int          mon_tag;

  always @(negedge CLK) begin
    while (exp_q.size() > 0 && int'(exp_q[0][55:40]) <= cyc) begin
      mon_e    = exp_q.pop_front();
      mon_tag  = int'(mon_e[55:40]);
      mon_kind = int'(mon_e[39:32]);
      case (mon_kind)
        K_READY: mon_act = {31'd0, sb_if.issue_ready};
        K_BUSY:  mon_act = busy_mask;
        K_CNT:   mon_act = 32'(out_cnt);
        K_SPUR:  mon_act = {31'd0, spurious_wb};
        K_STALL: mon_act = stall_cycles;
        default: mon_act = {28'd0, sc_cnt};
      endcase
      n_checks = n_checks + 1;
      if (mon_tag != cyc) begin
        $display("FAIL %s cycle %0d: check left unsampled (now cycle %0d)",
                 kind_name(mon_kind), mon_tag, cyc);
      end else if (mon_act !== mon_e[31:0]) begin
        $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h",
                 kind_name(mon_kind), cyc, mon_act, mon_e[31:0]);
      end else begin
        n_pass = n_pass + 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_issue(input logic v, input logic [4:0] rs1, input logic u1,
                           input logic [4:0] rs2, input logic u2,
                           input logic [4:0] rd, input logic wr);
    sb_if.issue_valid   = v;
    sb_if.issue_rs1     = rs1;
    sb_if.issue_use_rs1 = u1;
    sb_if.issue_rs2     = rs2;
    sb_if.issue_use_rs2 = u2;
    sb_if.issue_rd      = rd;
    sb_if.issue_wr_rd   = wr;
  endtask

  task automatic set_wb(input logic v, input logic [4:0] r);
    sb_if.wb_valid = v;
    sb_if.wb_reg   = r;
  endtask

  task automatic idle;
    set_issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RST_n  = 1'b0;
    flush  = 1'b0;
    sc_inc = 1'b0;
    idle();
    set_wb(1'b0, 5'd0);
    repeat (2) @(posedge CLK);
    #1 RST_n = 1'b1;

    // Reset state, then issue rd=5.
    push_exp(K_BUSY, 32'h0);
    push_exp(K_CNT, 32'd0);
    push_exp(K_SPUR, 32'd0);
    push_exp(K_STALL, 32'd0);
    set_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
    push_exp(K_READY, 32'd1);
    step();

    // RAW on x5 stalls.
    set_issue(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    push_exp(K_READY, 32'd0);
    push_exp(K_BUSY, 32'h20);
    push_exp(K_CNT, 32'd1);
    push_exp(K_STALL, 32'd0);
    step();

    // Write-back of x5 lands, still stalled this cycle.
    set_wb(1'b1, 5'd5);
    push_exp(K_READY, 32'd0);
    push_exp(K_STALL, 32'd1);
    step();

    // Next cycle the issue goes.
    set_wb(1'b0, 5'd0);
    push_exp(K_READY, 32'd1);
    push_exp(K_BUSY, 32'h0);
    push_exp(K_CNT, 32'd0);
    push_exp(K_STALL, 32'd2);
    step();

    // Fill to MAX_OUT with rd=1..4.
    for (int r = 1; r <= 4; r++) begin
      set_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'(r), 1'b1);
      push_exp(K_READY, 32'd1);
      step();
    end

    // Full: a further write stalls.
    set_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1);
    push_exp(K_CNT, 32'd4);
    push_exp(K_BUSY, 32'h1E);
    push_exp(K_READY, 32'd0);
    step();

    // Non-writing instruction with free sources is accepted while full.
    set_issue(1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 5'd6, 1'b0);
    push_exp(K_READY, 32'd1);
    push_exp(K_STALL, 32'd3);
    step();

    // Flush with an otherwise acceptable issue and a spurious-looking wb.
    set_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b0);
    flush = 1'b1;
    set_wb(1'b1, 5'd12);
    push_exp(K_READY, 32'd0);
    push_exp(K_BUSY, 32'h1E);
    push_exp(K_CNT, 32'd4);
    step();

    // Flush cleared everything; now issue rd=0.
    flush = 1'b0;
    set_wb(1'b0, 5'd0);
    set_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    push_exp(K_BUSY, 32'h0);
    push_exp(K_CNT, 32'd0);
    push_exp(K_SPUR, 32'd0);
    push_exp(K_STALL, 32'd3);
    push_exp(K_READY, 32'd1);
    step();

    // Write-back to x0 is ignored.
    idle();
    set_wb(1'b1, 5'd0);
    push_exp(K_BUSY, 32'h0);
    push_exp(K_CNT, 32'd0);
    step();

    // Spurious write-back to x9.
    set_wb(1'b1, 5'd9);
    push_exp(K_BUSY, 32'h0);
    push_exp(K_CNT, 32'd0);
    push_exp(K_SPUR, 32'd0);
    step();

    set_wb(1'b0, 5'd0);
    push_exp(K_SPUR, 32'd1);
    step();

    // Same-register accept and write-back: the set wins.
    push_exp(K_SPUR, 32'd1);
    set_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
    set_wb(1'b1, 5'd9);
    push_exp(K_READY, 32'd1);
    step();

    // Different-register accept and write-back: count unchanged.
    push_exp(K_BUSY, 32'h200);
    push_exp(K_CNT, 32'd1);
    push_exp(K_SPUR, 32'd1);
    set_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1);
    set_wb(1'b1, 5'd9);
    push_exp(K_READY, 32'd1);
    step();

    // Stall on x10.
    set_wb(1'b0, 5'd0);
    push_exp(K_BUSY, 32'h400);
    push_exp(K_CNT, 32'd1);
    set_issue(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    push_exp(K_READY, 32'd0);
    step();

    push_exp(K_STALL, 32'd4);
    push_exp(K_READY, 32'd0);
    step();

    // Asynchronous reset pulse between edges, mid-stall.
    #2 RST_n = 1'b0;
    push_exp(K_BUSY, 32'h0);
    push_exp(K_CNT, 32'd0);
    push_exp(K_SPUR, 32'd0);
    push_exp(K_STALL, 32'd0);
    push_exp(K_READY, 32'd1);
    @(negedge CLK);
    #1;
    RST_n = 1'b1;
    idle();
    step();

    push_exp(K_BUSY, 32'h0);
    push_exp(K_STALL, 32'd0);

    // Saturation on the narrow counter.
    sc_inc = 1'b1;
    step();
    step();
    step();
    push_exp(K_SAT, 32'd3);
    repeat (17) step();
    push_exp(K_SAT, 32'd15);
    step();
    push_exp(K_SAT, 32'd15);
    sc_inc = 1'b0;
    step();
    step();

    if (exp_q.size() != 0) begin
      n_checks = n_checks + 1;
      $display("FAIL drain: %0d checks never sampled, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Hazard scoreboard and issue controller for the 32×32 register file of the RISC-V micro. It tracks which architectural registers have a write in flight and gates instruction issue until every source and destination register is free. It also bounds the number of outstanding writes and accounts stall cycles for performance counting. It sits between decode/issue and the register file's write-back port (RegWrite/writeReg).

## Interface
Parameters:
- MAX_OUT, 4: maximum writes in flight (1..31).
- CNT_W, $clog2(MAX_OUT+1): width of the outstanding counter.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  decoded instruction presented.
- issue_rs1, issue_rs2  in  5 each  source register indices.
- issue_use_rs1, issue_use_rs2  in  1 each  the source is actually read.
- issue_rd  in  5  destination index.
- issue_wr_rd  in  1  the instruction writes rd.
- issue_ready  out  1  the instruction is accepted this cycle.
- wb_valid  in  1  a write-back is landing this cycle (mirrors RegWrite).
- wb_reg  in  5  write-back index (mirrors writeReg).
- flush  in  1  pipeline flush; discard all in-flight state.
- busy_mask  out  32  pending-write bit per register.
- out_cnt  out  CNT_W  number of pending writes.
- spurious_wb  out  1  sticky error flag.
- stall_cycles  out  32  saturating stall counter.

## Operation
Hazard check (combinational):
- haz = (use_rs1 & busy[rs1]) | (use_rs2 & busy[rs2]) | (wr_rd & busy[rd]).
- full = wr_rd & (out_cnt == MAX_OUT).
- issue_ready = issue_valid & ~flush & ~haz & ~full.

Register x0:
- Never pending. busy_mask[0] is constant 0.
- An issue with rd = 0 sets no bit and does not increment out_cnt.
- A write-back with wb_reg = 0 is ignored entirely.

Accept:
- On issue_ready & wr_rd & (rd != 0): set busy[rd] and increment out_cnt.

Write-back:
- On wb_valid & (wb_reg != 0) & busy[wb_reg]: clear the bit and decrement out_cnt.
- On wb_valid & (wb_reg != 0) & ~busy[wb_reg]: no state change; set spurious_wb.

Simultaneous accept and write-back:
- Different registers: both take effect; out_cnt is unchanged.
- Same register (the bit was clear, so the write-back is spurious): the set wins, out_cnt increments, and spurious_wb is set.

No bypass:
- A write-back in cycle t does not unblock an issue in cycle t.
- The register file commits at the edge and its read in cycle t returns the old value, so the issue stalls until t+1.

Flush:
- At the next edge all busy bits and out_cnt go to 0.
- issue_ready is forced to 0 during flush.
- A concurrent write-back is discarded silently and does not set spurious_wb.

stall_cycles:
- Increments on every cycle with issue_valid & ~issue_ready & ~flush.
- Saturates at 0xFFFF_FFFF.
- Cleared only by reset.

spurious_wb:
- Sticky. Cleared only by reset.

## Timing
- Reset (asynchronous, RST_n low): busy_mask = 0, out_cnt = 0, spurious_wb = 0, stall_cycles = 0. issue_ready evaluates to 0 unless issue_valid is asserted with no hazard.
- issue_ready is combinational from the inputs and current state, with zero latency.
- Busy set and clear become visible one cycle after the accepting or write-back edge.
- Reset asserted mid-operation: all state clears immediately, with no dependence on CLK.
- Handshake: the issuer holds its fields stable while issue_valid & ~issue_ready. The instruction is consumed on the edge where both are high.

## Structure
- Shared package rv_pkg:
  - typedef logic [4:0] reg_idx_t.
  - localparam NUM_REGS = 32.
  - localparam REG_X0 = 5'd0.
- The register file uses the same package.
- One sub-module: sat_counter (parameterised width, inc enable, saturating), instanced for stall_cycles.
- The busy vector, out_cnt and error flag live in the top-level always_ff. The hazard logic lives in always_comb.

## Test plan
- Reset, then issue rd=5 (wr_rd=1) -> issue_ready=1; next cycle busy_mask=0x20 and out_cnt=1. Issue rs1=5 -> issue_ready=0 and stall_cycles increments each cycle. wb_reg=5 at cycle t -> still stalled at t, issue_ready=1 at t+1.
- MAX_OUT=4: issue rd=1..4 back-to-back -> out_cnt=4. Issue rd=6 -> stalled (full). An issue with wr_rd=0 and free sources -> accepted.
- Issue rd=0, then wb_reg=0 -> busy_mask stays 0, out_cnt stays 0, spurious_wb stays 0.
- wb_reg=9 with busy[9]=0 -> spurious_wb=1 and stays 1. Issue rd=9 with wb_reg=9 in the same cycle -> busy[9]=1 and out_cnt increments.
- With busy_mask=0x1E and out_cnt=4, assert flush with issue_valid=1 -> issue_ready=0; next cycle busy_mask=0 and out_cnt=0.
- Pulse RST_n low between clock edges mid-stall -> all outputs 0 immediately. Force stall_cycles near 0xFFFF_FFFF -> it holds at saturation.
